// File: rtl/dmd_pkg.sv
// dmd_pkg: shared timing defaults, pipeline record and helper functions for the DMD video generator.
package dmd_pkg;
  localparam int H_ACTIVE_DEF = 800;
  localparam int H_FP_DEF = 40;
  localparam int H_SYNC_DEF = 128;
  localparam int H_BP_DEF = 88;
  localparam int V_ACTIVE_DEF = 600;
  localparam int V_FP_DEF = 1;
  localparam int V_SYNC_DEF = 4;
  localparam int V_BP_DEF = 23;
  typedef struct packed {
    logic win;
    logic gap;
    logic da;
    logic hs;
    logic vs;
    logic fs;
  } pipe_t;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
  // Replicates the bpp-bit intensity down from the MSB until all 8 bits are filled.
  function automatic logic [7:0] bright8(input logic [7:0] d, input int bpp);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i += bpp) r = (r >> bpp) | (d << (8 - bpp));
    return r;
  endfunction
  function automatic logic [7:0] cscale(input logic [7:0] c, input logic [7:0] b);
    logic [15:0] p;
    p = c * b;
    return p[15:8];
  endfunction
endpackage

// File: rtl/dmd_timing.sv
// dmd_timing: raster counters with sync and active-area decode.
module dmd_timing
  import dmd_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP = H_FP_DEF,
  parameter int H_SYNC = H_SYNC_DEF,
  parameter int H_BP = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP = V_FP_DEF,
  parameter int V_SYNC = V_SYNC_DEF,
  parameter int V_BP = V_BP_DEF,
  parameter bit SYNC_POL = 1'b1,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW = clog2(H_TOTAL),
  localparam int VW = clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          rst,
  output logic [HW-1:0] h_cnt,
  output logic [VW-1:0] v_cnt,
  output logic          h_last,
  output logic          v_last,
  output logic          hs,
  output logic          vs,
  output logic          da
);
  always_comb begin
    h_last = h_cnt == HW'(H_TOTAL - 1);
    v_last = v_cnt == VW'(V_TOTAL - 1);
    hs = (h_cnt >= HW'(H_ACTIVE + H_FP) && h_cnt < HW'(H_ACTIVE + H_FP + H_SYNC)) ? SYNC_POL : ~SYNC_POL;
    vs = (v_cnt >= VW'(V_ACTIVE + V_FP) && v_cnt < VW'(V_ACTIVE + V_FP + V_SYNC)) ? SYNC_POL : ~SYNC_POL;
    da = h_cnt < HW'(H_ACTIVE) && v_cnt < VW'(V_ACTIVE);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      h_cnt <= h_last ? '0 : h_cnt + 1'b1;
      if (h_last) v_cnt <= v_last ? '0 : v_cnt + 1'b1;
    end
endmodule

// File: rtl/dmd_video_gen.sv
// dmd_video_gen: scales a banked dot-matrix frame buffer into a tinted raster video stream.
module dmd_video_gen
  import dmd_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP = H_FP_DEF,
  parameter int H_SYNC = H_SYNC_DEF,
  parameter int H_BP = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP = V_FP_DEF,
  parameter int V_SYNC = V_SYNC_DEF,
  parameter int V_BP = V_BP_DEF,
  parameter bit SYNC_POL = 1'b1,
  parameter int DMD_W = 128,
  parameter int DMD_H = 32,
  parameter int SCALE = 6,
  parameter int X_OFF = 16,
  parameter int Y_OFF = 204,
  parameter int BPP = 4,
  localparam int ADDR_W = clog2(DMD_W * DMD_H) + 1
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [BPP-1:0]    rd_data,
  input  logic [23:0]       tint,
  input  logic              dot_gap,
  input  logic              swap_req,
  output logic              swap_ack,
  output logic              display_bank,
  output logic              hSync,
  output logic              vSync,
  output logic              DrawArea,
  output logic [7:0]        red,
  output logic [7:0]        green,
  output logic [7:0]        blue,
  output logic              frame_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = clog2(H_TOTAL);
  localparam int VW = clog2(V_TOTAL);
  localparam int XW = clog2(DMD_W + 1);
  localparam int YW = clog2(DMD_H + 1);
  localparam int SW = clog2(SCALE + 1);
  localparam int IW = ADDR_W - 1;
  localparam pipe_t PIPE_RST = '{win: 1'b0, gap: 1'b0, da: 1'b0, hs: ~SYNC_POL, vs: ~SYNC_POL, fs: 1'b0};
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic h_last, v_last, hs, vs, da;
  logic [XW-1:0] dx;
  logic [YW-1:0] dy;
  logic [SW-1:0] sx, sy;
  logic xon, yon, gap_l, origin, do_swap, bank_next, x_start, y_start, vis;
  logic [23:0] tint_l;
  logic [7:0] b8;
  pipe_t s0, s1, s2;
  dmd_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .SYNC_POL(SYNC_POL)
  ) u_timing (
    .clk(clk), .rst(rst), .h_cnt(h_cnt), .v_cnt(v_cnt),
    .h_last(h_last), .v_last(v_last), .hs(hs), .vs(vs), .da(da)
  );
  // Window edges are detected one pixel/line early so the sub-dot counters restart exactly on X_OFF/Y_OFF.
  always_comb begin
    origin = h_cnt == '0 && v_cnt == '0;
    do_swap = origin && swap_req;
    bank_next = display_bank ^ do_swap;
    x_start = h_cnt == HW'((X_OFF + H_TOTAL - 1) % H_TOTAL);
    y_start = h_last && v_cnt == VW'((Y_OFF + V_TOTAL - 1) % V_TOTAL);
    s0.win = xon && yon && dx < XW'(DMD_W) && dy < YW'(DMD_H);
    s0.gap = (origin ? dot_gap : gap_l) && (sx == SW'(SCALE - 1) || sy == SW'(SCALE - 1));
    s0.da = da;
    s0.hs = hs;
    s0.vs = vs;
    s0.fs = origin;
    vis = s2.win && s2.da && !s2.gap;
    b8 = bright8(8'(rd_data), BPP);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sx <= '0;
      dx <= '0;
      xon <= (X_OFF == 0);
      sy <= '0;
      dy <= '0;
      yon <= (Y_OFF == 0);
    end else begin
      xon <= x_start || (xon && !h_last);
      sx <= (x_start || sx == SW'(SCALE - 1)) ? '0 : sx + 1'b1;
      dx <= x_start ? '0 : (sx == SW'(SCALE - 1) && dx != XW'(DMD_W)) ? dx + 1'b1 : dx;
      if (h_last) begin
        yon <= y_start || (yon && !v_last);
        sy <= (y_start || sy == SW'(SCALE - 1)) ? '0 : sy + 1'b1;
        dy <= y_start ? '0 : (sy == SW'(SCALE - 1) && dy != YW'(DMD_H)) ? dy + 1'b1 : dy;
      end
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      display_bank <= 1'b0;
      swap_ack <= 1'b0;
      tint_l <= '0;
      gap_l <= 1'b0;
      rd_addr <= '0;
      s1 <= PIPE_RST;
      s2 <= PIPE_RST;
      red <= '0;
      green <= '0;
      blue <= '0;
      DrawArea <= 1'b0;
      hSync <= ~SYNC_POL;
      vSync <= ~SYNC_POL;
      frame_start <= 1'b0;
    end else begin
      display_bank <= bank_next;
      swap_ack <= do_swap;
      if (origin) begin
        tint_l <= tint;
        gap_l <= dot_gap;
      end
      if (s0.win) rd_addr <= {bank_next, IW'(dy * DMD_W + dx)};
      s1 <= s0;
      s2 <= s1;
      red <= vis ? cscale(tint_l[23:16], b8) : '0;
      green <= vis ? cscale(tint_l[15:8], b8) : '0;
      blue <= vis ? cscale(tint_l[7:0], b8) : '0;
      DrawArea <= s2.da;
      hSync <= s2.hs;
      vSync <= s2.vs;
      frame_start <= s2.fs;
    end
endmodule
